// File: rtl/pdm_playback_ctrl.sv
// Playback sequencer: fetches samples from sample RAM and feeds them frame by frame to the PDM Serializer.
// Optional PDM_LOOP_EN: restart from the latched base address at end of playback when loop_i is high.
module pdm_playback_ctrl #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              play_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] length_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] ser_data_o,
    output logic              ser_enable_o,
    input  logic              ser_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] words_played_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_LOAD,
        S_SHIFT,
        S_NEXT
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   count_q;
    logic [WD_W-1:0]     wd_q;
    logic [DATA_W-1:0]   ser_data_q;
    logic                mem_rd_q;
    logic                ser_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [ADDR_W-1:0]   count_d;
    logic                loop_en;

    assign count_d = count_q + ADDR_W'(1);

`ifdef PDM_LOOP_EN
    assign loop_en = loop_i;
`else
    logic unused_loop;
    assign unused_loop = loop_i;
    assign loop_en     = 1'b0;
`endif

    // Sequencer: state and every output are registered together.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            wd_q       <= '0;
            ser_data_q <= '0;
            mem_rd_q   <= 1'b0;
            ser_en_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            ser_en_q <= 1'b1;
            done_q   <= 1'b0;
            if (state_q != S_IDLE && stop_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (play_i && !stop_i) begin
                            err_q <= 1'b0;
                            if (length_i != '0) begin
                                base_q   <= base_addr_i;
                                len_q    <= length_i;
                                addr_q   <= base_addr_i;
                                count_q  <= '0;
                                mem_rd_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= S_FETCH;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: state_q <= S_CAPTURE;
                    S_CAPTURE: begin
                        ser_data_q <= mem_data_i;
                        ser_en_q   <= 1'b0;
                        state_q    <= S_LOAD;
                    end
                    S_LOAD: begin
                        wd_q    <= '0;
                        state_q <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // done_o is raised on entry to NEXT so it precedes busy_o falling
                        if (ser_done_i) begin
                            count_q <= count_d;
                            done_q  <= (count_d == len_q);
                            state_q <= S_NEXT;
                        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (count_q == len_q) begin
                            if (loop_en) begin
                                count_q  <= '0;
                                addr_q   <= base_q;
                                mem_rd_q <= 1'b1;
                                state_q  <= S_FETCH;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            addr_q   <= addr_q + ADDR_W'(1);
                            mem_rd_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_rd_o       = mem_rd_q;
    assign mem_addr_o     = addr_q;
    assign ser_data_o     = ser_data_q;
    assign ser_enable_o   = ser_en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_played_o = count_q;

endmodule

// File: doc/pdm_playback_ctrl.md
Name: pdm_playback_ctrl

Overview:
- Sequences the existing PDM Serializer during playback of recorded audio.
- Fetches 16-bit samples from the sample RAM, then loads each one into the Serializer and starts a frame.
- Waits for the Serializer's done, then advances to the next word until the programmed length is played.
- Sits between the recorder's sample BRAM and the Serializer, under the top-level button/mode logic.

Parameters:
ADDR_W, 17, sample RAM address width; also the width of length and count
DATA_W, 16, sample width; must match the Serializer data_i width
TIMEOUT, 64, max clock cycles to wait for ser_done_i in SHIFT before aborting

Ports:
clock_i  in  1  system clock, all logic rising-edge
reset_n_i  in  1  synchronous active-low reset
play_i  in  1  one-cycle start pulse
stop_i  in  1  one-cycle abort pulse
loop_i  in  1  repeat playback at end (effective only with PDM_LOOP_EN)
base_addr_i  in  ADDR_W  first sample address, latched on start
length_i  in  ADDR_W  number of words to play, latched on start
mem_rd_o  out  1  RAM read strobe
mem_addr_o  out  ADDR_W  RAM read address
mem_data_i  in  DATA_W  RAM read data, valid 1 cycle after mem_rd_o
ser_data_o  out  DATA_W  to Serializer data_i, held stable for the whole frame
ser_enable_o  out  1  to Serializer enable_i; active-low, idle high, one-cycle low pulse starts a frame
ser_done_i  in  1  from Serializer done_o; frame complete
busy_o  out  1  high in any non-IDLE state
done_o  out  1  one-cycle pulse when a playback completes normally
err_o  out  1  sticky watchdog error
words_played_o  out  ADDR_W  frames completed in the current playback

Behaviour:
- Reset (reset_n_i low at an edge): state IDLE; all outputs 0 except ser_enable_o=1; internal address, length, count and watchdog cleared.
- Reset mid-frame behaves the same. The Serializer may keep shifting; any later ser_done_i is ignored.
- States: IDLE, FETCH, CAPTURE, LOAD, SHIFT, NEXT.
- IDLE:
  - play_i=1, stop_i=0, length_i!=0: latch base and length, addr=base, count=0, clear err_o, go to FETCH.
  - play_i with length_i=0: clear err_o, pulse done_o next cycle, stay IDLE, no RAM read.
- FETCH: mem_rd_o=1, mem_addr_o=addr, for one cycle -> CAPTURE.
- CAPTURE: ser_data_o <= mem_data_i -> LOAD.
- LOAD: ser_enable_o=0 for exactly one cycle, watchdog=0 -> SHIFT.
- SHIFT:
  - Hold ser_data_o; increment watchdog each cycle.
  - ser_done_i=1: count+1 -> NEXT.
  - Watchdog reaches TIMEOUT-1 without ser_done_i: err_o=1, go to IDLE, no done_o.
- NEXT:
  - If count==length: done_o=1 for one cycle, go to IDLE.
  - Otherwise addr+1 (mod 2^ADDR_W, wraps silently) -> FETCH.
- Latency: play_i sampled at edge k gives mem_rd_o high in cycle k+1, capture in k+2, ser_enable_o low in k+3, SHIFT from k+4.
- Per-word overhead beyond the Serializer frame: NEXT + FETCH + CAPTURE + LOAD = 4 cycles.
- words_played_o = count, updated on entry to NEXT; holds its value in IDLE until the next start.
- stop_i in any non-IDLE state: go to IDLE next edge, ser_enable_o=1, no done_o, err_o unchanged.
- Simultaneous events:
  - stop_i and play_i together: stop wins and nothing starts.
  - play_i while busy_o=1: ignored.
  - ser_done_i outside SHIFT: ignored.
  - stop_i in the same cycle ser_done_i arrives in SHIFT: stop wins and count is not incremented.
- mem_rd_o is never asserted outside FETCH.

Optional Feature:
- Macro: PDM_LOOP_EN.
- Defined: in NEXT with count==length and loop_i=1, pulse done_o, reset count=0 and addr=latched base, and go to FETCH. busy_o stays high; only stop_i, a timeout or reset end playback.
- Undefined: loop_i ignored (port kept, unused); playback always ends in IDLE.

Test Plan:
- Reset then play_i, base=0x00010, length=3, RAM[n]=0x0F0F+n, Serializer model done 16 cycles after enable:
  - ser_data_o presented 0x0F1F, 0x0F20, 0x0F21 in order, one ser_enable_o low pulse each.
  - done_o pulses once; words_played_o=3; busy_o drops the cycle after done_o.
- Check cycle timing: play_i at edge k -> mem_rd_o in k+1, ser_enable_o low in k+3; ser_data_o does not change between the enable pulse and ser_done_i.
- Model never asserts done, TIMEOUT=64:
  - err_o=1 and return to IDLE 64 cycles after entering SHIFT; no done_o.
  - The next play_i clears err_o.
- stop_i during the second SHIFT of a length-5 playback: IDLE next edge, words_played_o=1, no done_o; a late ser_done_i changes nothing.
- Edge cases:
  - play_i with length=0: done_o pulse, no mem_rd_o.
  - play_i+stop_i together: no start.
  - base=0x1FFFF, length=2: addresses 0x1FFFF then 0x00000.
- With PDM_LOOP_EN, loop_i=1, length=2: addresses base, base+1, base, base+1...; done_o pulses each pass; stop_i ends playback. Without the macro, a single pass.
